// File: rtl/ahb5_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ahb5_bus_arbiter
//
// Round-robin AHB5 bus arbiter with grant parking on master 0, a hold
// counter that forces re-arbitration of long unlocked ownerships at a
// burst-safe point, optional locked-transfer support, and address/data
// phase owner tracking.
//
// Optional feature macro: AHB5_ARB_LOCK_EN
//   defined   -> HLOCK is honoured, the LOCKED state is reachable and
//                HMASTLOCK reports the lock of the address-phase owner.
//   undefined -> HLOCK is ignored, LOCKED is unreachable, HMASTLOCK is 0.
//
// Ports
//   Hclk       in   bus clock, all state updates on its rising edge
//   HReset     in   asynchronous active-high reset
//   HBUSREQ    in   per-master bus request
//   HLOCK      in   per-master locked-transfer request
//   HTRANS     in   transfer type of the address-phase owner
//   HREADY     in   bus ready, arbitration and phase handover only when 1
//   HGRANT     out  registered one-hot grant
//   HMASTER    out  index of the address-phase owner
//   HMASTER_D  out  index of the data-phase owner
//   HMASTLOCK  out  address-phase transfer is locked
// ---------------------------------------------------------------------------
module ahb5_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int MAX_HOLD    = 16
) (
  input  logic                           Hclk,
  input  logic                           HReset,
  input  logic [NUM_MASTERS-1:0]         HBUSREQ,
  input  logic [NUM_MASTERS-1:0]         HLOCK,
  input  logic [1:0]                     HTRANS,
  input  logic                           HREADY,
  output logic [NUM_MASTERS-1:0]         HGRANT,
  output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
  output logic [$clog2(NUM_MASTERS)-1:0] HMASTER_D,
  output logic                           HMASTLOCK
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] TRANS_BUSY = 2'b01;
  localparam logic [1:0] TRANS_SEQ  = 2'b11;

  typedef enum logic [1:0] {
    PARK   = 2'd0,
    OWN    = 2'd1,
    LOCKED = 2'd2
  } arbState_t;

  arbState_t        r_state;
  logic [IW-1:0]    r_last;
  logic [CW-1:0]    r_count;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]    r_hmaster;
  logic [IW-1:0]    r_hmasterD;
  logic             r_mastLock;

  logic [NUM_MASTERS-1:0] w_lock;
  logic [NUM_MASTERS-1:0] w_search;
  logic [IW-1:0]    w_owner;
  logic [IW-1:0]    w_pick;
  logic             w_found;
  logic             w_ownerReq;
  logic             w_ownerLock;
  logic             w_midBurst;
  logic             w_rearb;

`ifdef AHB5_ARB_LOCK_EN
  assign w_lock = HLOCK;
`else
  logic w_unusedLock;
  assign w_lock       = '0;
  assign w_unusedLock = ^HLOCK;
`endif

  // Owner decode, round-robin search and the re-arbitration decision.
  // While parked the grant sits on master 0 but the round-robin pointer
  // keeps the last real owner, so the search resumes after it. When an
  // owner is being re-arbitrated it is masked out of the search; if
  // nobody else is found the keep/park decision is made by the FSM.
  always_comb begin
    w_owner     = (r_state == PARK) ? '0 : r_last;
    w_ownerReq  = HBUSREQ[w_owner];
    w_ownerLock = w_lock[w_owner];
    w_search    = (r_state == PARK) ? HBUSREQ
                                    : (HBUSREQ & ~(NUM_MASTERS'(1) << w_owner));
    w_found     = 1'b0;
    w_pick      = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!w_found && w_search[IW'((int'(r_last) + k) % NUM_MASTERS)]) begin
        w_found = 1'b1;
        w_pick  = IW'((int'(r_last) + k) % NUM_MASTERS);
      end
    end
    w_midBurst = (HTRANS == TRANS_SEQ) || (HTRANS == TRANS_BUSY);
    case (r_state)
      OWN:     w_rearb = !w_ownerReq ||
                         ((r_count == CW'(MAX_HOLD)) && !w_midBurst);
      LOCKED:  w_rearb = !w_ownerLock;
      default: w_rearb = 1'b0;
    endcase
  end

  // Arbitration FSM with registered grant and phase-owner outputs.
  // Nothing moves on a wait-state cycle. HMASTER follows the grant one
  // ready edge later and HMASTER_D follows HMASTER one ready edge later.
  always_ff @(posedge Hclk or posedge HReset) begin
    if (HReset) begin
      r_state    <= PARK;
      r_last     <= '0;
      r_count    <= '0;
      r_grant    <= NUM_MASTERS'(1);
      r_hmaster  <= '0;
      r_hmasterD <= '0;
      r_mastLock <= 1'b0;
    end else if (HREADY) begin
      r_hmasterD <= r_hmaster;
      r_hmaster  <= w_owner;
      r_mastLock <= w_ownerLock;
      case (r_state)
        PARK: begin
          if (w_found) begin
            r_state <= w_lock[w_pick] ? LOCKED : OWN;
            r_last  <= w_pick;
            r_grant <= NUM_MASTERS'(1) << w_pick;
            r_count <= '0;
          end else begin
            r_grant <= NUM_MASTERS'(1);
          end
        end
        OWN, LOCKED: begin
          if (w_rearb) begin
            if (w_found) begin
              r_state <= w_lock[w_pick] ? LOCKED : OWN;
              r_last  <= w_pick;
              r_grant <= NUM_MASTERS'(1) << w_pick;
              r_count <= '0;
            end else if (w_ownerReq) begin
              r_state <= w_ownerLock ? LOCKED : OWN;
              r_count <= '0;
            end else begin
              r_state <= PARK;
              r_grant <= NUM_MASTERS'(1);
              r_count <= '0;
            end
          end else if (r_state == OWN && r_count != CW'(MAX_HOLD)) begin
            r_count <= r_count + CW'(1);
          end
        end
        default: begin
          r_state <= PARK;
          r_grant <= NUM_MASTERS'(1);
          r_count <= '0;
        end
      endcase
    end
  end

  assign HGRANT    = r_grant;
  assign HMASTER   = r_hmaster;
  assign HMASTER_D = r_hmasterD;
  assign HMASTLOCK = r_mastLock;

endmodule

// File: tb/tb_ahb5_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb5_bus_arbiter
//
// Scoreboard bench for ahb5_bus_arbiter. The stimulus process drives the
// inputs on the falling edge, advances a behavioural model of the arbiter
// by one bus edge and queues the expected outputs; a monitor process pops
// and compares them just after each rising edge. Directed phases cover
// reset, round-robin alternation, wait states, SEQ-burst protection,
// locking and asynchronous reset; a random phase follows.
// Honours AHB5_ARB_LOCK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_ahb5_bus_arbiter;

  localparam int N   = 4;
  localparam int MAX = 16;
  localparam int IW  = $clog2(N);

`ifdef AHB5_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam logic [1:0] T_IDLE   = 2'd0;
  localparam logic [1:0] T_NONSEQ = 2'd2;
  localparam logic [1:0] T_SEQ    = 2'd3;

  logic          Hclk = 1'b0;
  logic          HReset = 1'b1;
  logic [N-1:0]  HBUSREQ = '0;
  logic [N-1:0]  HLOCK = '0;
  logic [1:0]    HTRANS = T_IDLE;
  logic          HREADY = 1'b1;
  logic [N-1:0]  HGRANT;
  logic [IW-1:0] HMASTER;
  logic [IW-1:0] HMASTER_D;
  logic          HMASTLOCK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] grant;
    int           hm;
    int           hmd;
    bit           ml;
  } expT;

  expT   expQ[$];
  string tagQ[$];

  // Behavioural model: who owns the bus, whether it is parked or locked,
  // how long it has held, and which master was granted last.
  bit mParked;
  bit mLocked;
  int mOwner;
  int mHold;
  int mPtr;
  int mHm;
  int mHmD;
  bit mMl;

  ahb5_bus_arbiter #(.NUM_MASTERS(N), .MAX_HOLD(MAX)) dut (
    .Hclk      (Hclk),
    .HReset    (HReset),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HTRANS    (HTRANS),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTER_D (HMASTER_D),
    .HMASTLOCK (HMASTLOCK)
  );

  always #5 Hclk = ~Hclk;

  // First requester after 'from' in circular order, ignoring 'skip'.
  function automatic int findNext(input logic [N-1:0] req, input int from, input int skip);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (from + k) % N;
      if (req[c[IW-1:0]] && c != skip) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] modelGrant();
    logic [N-1:0] g;
    g = '0;
    g[mParked ? 0 : mOwner[IW-1:0]] = 1'b1;
    return g;
  endfunction

  task automatic modelReset();
    mParked = 1'b1;
    mLocked = 1'b0;
    mOwner  = 0;
    mHold   = 0;
    mPtr    = 0;
    mHm     = 0;
    mHmD    = 0;
    mMl     = 1'b0;
  endtask

  task automatic modelGive(input int m, input logic [N-1:0] lock);
    mParked = 1'b0;
    mOwner  = m;
    mPtr    = m;
    mHold   = 0;
    mLocked = LOCK_EN && lock[m[IW-1:0]];
  endtask

  // One rising edge with HREADY=1 and reset released.
  task automatic modelStep(input logic [N-1:0] req, input logic [N-1:0] lock,
                           input logic [1:0] trans);
    int cur;
    int nxt;
    bit rearb;
    cur  = mParked ? 0 : mOwner;
    mHmD = mHm;
    mHm  = cur;
    mMl  = LOCK_EN && lock[cur[IW-1:0]];
    if (mParked) begin
      nxt = findNext(req, mPtr, -1);
      if (nxt >= 0) modelGive(nxt, lock);
    end else begin
      if (mLocked)
        rearb = !lock[cur[IW-1:0]];
      else
        rearb = !req[cur[IW-1:0]] ||
                (mHold == MAX && (trans == T_IDLE || trans == T_NONSEQ));
      if (rearb) begin
        nxt = findNext(req, cur, cur);
        if (nxt >= 0) begin
          modelGive(nxt, lock);
        end else if (req[cur[IW-1:0]]) begin
          mHold   = 0;
          mLocked = LOCK_EN && lock[cur[IW-1:0]];
        end else begin
          mParked = 1'b1;
          mLocked = 1'b0;
          mHold   = 0;
        end
      end else if (!mLocked) begin
        mHold = (mHold < MAX) ? mHold + 1 : MAX;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] eg,
                             input int ehm, input int ehmd, input bit eml);
    checks++;
    if (HGRANT !== eg || !$onehot(HGRANT) || HMASTER !== ehm[IW-1:0] ||
        HMASTER_D !== ehmd[IW-1:0] || HMASTLOCK !== eml) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got HGRANT=%b HMASTER=%0d HMASTER_D=%0d HMASTLOCK=%b, expected HGRANT=%b HMASTER=%0d HMASTER_D=%0d HMASTLOCK=%b",
               name, $time, HGRANT, HMASTER, HMASTER_D, HMASTLOCK, eg, ehm, ehmd, eml);
    end
  endtask

  // Drive one cycle of inputs, advance the model past the coming edge and
  // queue what the outputs must look like afterwards.
  task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] lock,
                               input logic [1:0] trans, input logic ready,
                               input logic rst, input string name);
    expT e;
    @(negedge Hclk);
    HBUSREQ = req;
    HLOCK   = lock;
    HTRANS  = trans;
    HREADY  = ready;
    HReset  = rst;
    if (rst) modelReset();
    else if (ready) modelStep(req, lock, trans);
    e.grant = modelGrant();
    e.hm    = mHm;
    e.hmd   = mHmD;
    e.ml    = mMl;
    expQ.push_back(e);
    tagQ.push_back(name);
  endtask

  // Reset asserted between clock edges must take effect immediately.
  task automatic doReset(input string name);
    @(negedge Hclk);
    #2;
    HReset = 1'b1;
    modelReset();
    #1;
    checkOutput({name, "_async"}, N'(1), 0, 0, 1'b0);
    repeat (2) applyStimulus(HBUSREQ, HLOCK, HTRANS, 1'b1, 1'b1, name);
  endtask

  initial begin : monitor
    expT   e;
    string t;
    forever begin
      @(posedge Hclk);
      #1;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        t = tagQ.pop_front();
        checkOutput(t, e.grant, e.hm, e.hmd, e.ml);
      end
    end
  end

  initial begin : stimulus
    logic [N-1:0] rq;
    logic [N-1:0] lk;
    logic [1:0]   tr;
    logic         rd;

    modelReset();
    doReset("reset");
    repeat (10) applyStimulus(4'b0000, 4'b0000, T_IDLE, 1'b1, 1'b0, "idle_park");

    repeat (60) applyStimulus(4'b1010, 4'b0000, T_NONSEQ, 1'b1, 1'b0, "rr_1010");

    doReset("reset_ws");
    applyStimulus(4'b0100, 4'b0000, T_NONSEQ, 1'b1, 1'b0, "handover");
    repeat (5) applyStimulus(4'b0100, 4'b0000, T_NONSEQ, 1'b0, 1'b0, "wait_state");
    repeat (3) applyStimulus(4'b0100, 4'b0000, T_NONSEQ, 1'b1, 1'b0, "handover_done");

    doReset("reset_seq");
    applyStimulus(4'b0001, 4'b0000, T_NONSEQ, 1'b1, 1'b0, "seq_start");
    repeat (20) applyStimulus(4'b0001, 4'b0000, T_SEQ, 1'b1, 1'b0, "seq_burst");
    repeat (10) applyStimulus(4'b0011, 4'b0000, T_SEQ, 1'b1, 1'b0, "seq_protect");
    repeat (4) applyStimulus(4'b0011, 4'b0000, T_IDLE, 1'b1, 1'b0, "seq_release");

    doReset("reset_lock");
    applyStimulus(4'b0100, 4'b0100, T_NONSEQ, 1'b1, 1'b0, "lock_grant");
    repeat (40) applyStimulus(4'b1111, 4'b0100, T_NONSEQ, 1'b1, 1'b0, "lock_hold");
    repeat (4) applyStimulus(4'b1111, 4'b0000, T_NONSEQ, 1'b1, 1'b0, "lock_drop");

    repeat (4) applyStimulus(4'b1000, 4'b1000, T_NONSEQ, 1'b1, 1'b0, "lock_m3");
    doReset("reset_locked");
    repeat (3) applyStimulus(4'b1000, 4'b1000, T_NONSEQ, 1'b1, 1'b0, "after_reset");

    rq = '0;
    lk = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) rq = N'($urandom);
      if ($urandom_range(7) == 0) lk = N'($urandom) & rq;
      else lk = lk & rq;
      tr = 2'($urandom);
      rd = ($urandom_range(9) != 0);
      applyStimulus(rq, lk, tr, rd, 1'b0, "random");
      if ($urandom_range(999) == 0) doReset("random_reset");
    end

    repeat (3) @(posedge Hclk);
    #2;
    if (expQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
